// File: rtl/usb_phy_tx.sv
// usb_phy_tx -- USB full/low-speed line transmitter.
// Serialises bytes into an NRZI, bit-stuffed D+/D- stream framed by a SYNC
// pattern and an SE0/SE0/J end-of-packet. It can also send a bare low-speed
// EOP as a keep-alive.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   usb_full_speed   1 = full-speed, 0 = low-speed (latched when a packet starts)
//   tx_data/tx_valid byte source; tx_ready pulses for one clk when a byte is taken
//   keep_alive       pulse request for a low-speed keep-alive EOP
//   d_o              driven {p,n} line levels
//   d_en             output-driver enable; busy mirrors it

package usb_phy_tx_pkg;
    typedef struct packed {
        logic p;
        logic n;
    } d_port_t;
endpackage

module usb_phy_tx
    import usb_phy_tx_pkg::*;
#(
    parameter int FS_DIV    = 4,
    parameter int LS_DIV    = 32,
    parameter int SYNC_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_full_speed,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       keep_alive,
    output d_port_t    d_o,
    output logic       d_en,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    localparam d_port_t SE0 = '{p: 1'b0, n: 1'b0};

    state_t     state;
    logic       fs_lat;    // speed captured when the packet started
    logic [7:0] div_cnt;   // clk count within the current line bit
    logic [4:0] bit_cnt;   // SYNC bit index, data bit index, or EOP bit index
    logic [2:0] ones;      // run of consecutive 1 bits on the wire
    logic       stuff;     // current line bit is an inserted stuff bit
    logic [7:0] shreg;     // remaining bits of the byte being sent, LSB next
    logic       line_j;    // NRZI line level, 1 = J

    // J/K levels depend on speed: full-speed J is {1,0}, low-speed J is {0,1}.
    function automatic d_port_t lvl(input logic j, input logic fs);
        d_port_t d;
        d.p = j ? fs : ~fs;
        d.n = ~d.p;
        return d;
    endfunction

    logic [7:0] div_last;
    logic       bit_end;
    logic       boundary;
    logic       need_stuff;
    logic       nxt_bit;
    logic       nxt_line;
    logic [2:0] ones_next;

    assign div_last = fs_lat ? 8'(FS_DIV - 1) : 8'(LS_DIV - 1);
    assign bit_end  = (div_cnt == div_last);

    // Decide, for the bit currently on the wire, what follows it.
    always_comb begin
        boundary   = 1'b0;
        need_stuff = 1'b0;
        ones_next  = 3'd0;
        nxt_bit    = 1'b1;
        case (state)
            SYNC: begin
                boundary  = (bit_cnt == 5'(SYNC_BITS - 1));
                // SYNC's trailing 1 starts the stuffing run
                ones_next = boundary ? 3'd1 : 3'd0;
                nxt_bit   = (5'(bit_cnt + 5'd1) == 5'(SYNC_BITS - 1));
            end
            DATA: begin
                if (stuff) begin
                    // bit_cnt==8 means the stuff bit trails the byte's last bit
                    boundary = (bit_cnt == 5'd8);
                    nxt_bit  = shreg[0];
                end else begin
                    ones_next  = shreg[0] ? 3'(ones + 3'd1) : 3'd0;
                    need_stuff = (ones_next == 3'd6);
                    boundary   = (bit_cnt == 5'd7) && !need_stuff;
                    nxt_bit    = shreg[1];
                end
            end
            default: ;
        endcase
        if (need_stuff)
            nxt_bit = 1'b0;
        else if (boundary)
            nxt_bit = tx_data[0];
        // NRZI: a 0 toggles the line, a 1 holds it
        nxt_line = nxt_bit ? line_j : ~line_j;
    end

    // Byte is taken only in the last clk of a byte boundary bit.
    assign tx_ready = bit_end && boundary && tx_valid;
    assign busy     = d_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            fs_lat  <= usb_full_speed;
            div_cnt <= 8'd0;
            bit_cnt <= 5'd0;
            ones    <= 3'd0;
            stuff   <= 1'b0;
            shreg   <= 8'd0;
            line_j  <= 1'b1;
            d_o     <= lvl(1'b1, usb_full_speed);
            d_en    <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || bit_end) ? 8'd0 : div_cnt + 8'd1;
            case (state)
                IDLE: begin
                    fs_lat  <= usb_full_speed;
                    bit_cnt <= 5'd0;
                    ones    <= 3'd0;
                    stuff   <= 1'b0;
                    line_j  <= 1'b1;
                    d_o     <= lvl(1'b1, usb_full_speed);
                    if (tx_valid) begin
                        // first SYNC bit is a 0, so the line goes to K
                        state  <= SYNC;
                        line_j <= 1'b0;
                        d_o    <= lvl(1'b0, usb_full_speed);
                        d_en   <= 1'b1;
                    end else if (keep_alive && !usb_full_speed) begin
                        state <= EOP_SE0;
                        d_o   <= SE0;
                        d_en  <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (bit_end) begin
                        ones  <= ones_next;
                        stuff <= need_stuff;
                        if (state == DATA && !stuff)
                            shreg <= shreg >> 1;
                        // stuff bits do not advance the data bit counter
                        if (!(state == DATA && stuff))
                            bit_cnt <= bit_cnt + 5'd1;
                        if (boundary && !tx_valid) begin
                            state   <= EOP_SE0;
                            bit_cnt <= 5'd0;
                            d_o     <= SE0;
                        end else begin
                            if (boundary) begin
                                state   <= DATA;
                                shreg   <= tx_data;
                                bit_cnt <= 5'd0;
                            end
                            line_j <= nxt_line;
                            d_o    <= lvl(nxt_line, fs_lat);
                        end
                    end
                end
                EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_cnt == 5'd1) begin
                            state   <= EOP_J;
                            bit_cnt <= 5'd0;
                            line_j  <= 1'b1;
                            d_o     <= lvl(1'b1, fs_lat);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                EOP_J: begin
                    if (bit_end) begin
                        state <= IDLE;
                        d_en  <= 1'b0;
                        d_o   <= lvl(1'b1, usb_full_speed);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_phy_tx.sv
// Bench for usb_phy_tx: a bit-level model builds the expected per-clk line
// trace (SYNC, stuffed data, NRZI, EOP) for each transaction and one compare
// process checks d_en/busy/d_o/tx_ready against it every clk.
module tb_usb_phy_tx;
    import usb_phy_tx_pkg::*;

    localparam int FS_DIV    = 4;
    localparam int LS_DIV    = 32;
    localparam int SYNC_BITS = 8;

    typedef struct packed {
        logic en;
        logic p;
        logic n;
        logic rdy;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       usb_full_speed = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       keep_alive = 1'b0;
    logic       tx_ready;
    d_port_t    d_o;
    logic       d_en;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    rec_t mdl_q[$];
    rec_t exp_q[$];
    logic fs_smp = 1'b1;
    bit   armed = 1'b0;
    int   run_len = 0;
    int   last_run = 0;
    int   rdy_cnt = 0;

    always #5 clk = ~clk;

    usb_phy_tx #(.FS_DIV(FS_DIV), .LS_DIV(LS_DIV), .SYNC_BITS(SYNC_BITS)) dut (
        .clk(clk), .reset(reset), .usb_full_speed(usb_full_speed),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .keep_alive(keep_alive), .d_o(d_o), .d_en(d_en), .busy(busy)
    );

    // Idle line shows J of the speed seen at the previous edge.
    always @(posedge clk) fs_smp <= usb_full_speed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t lv(input bit j, input bit fs, input bit en, input bit rdy);
        rec_t r;
        r.en  = en;
        r.p   = j ? fs : !fs;
        r.n   = !r.p;
        r.rdy = rdy;
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t e;
        if (armed) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = lv(1'b1, fs_smp, 1'b0, 1'b0);
            chk("line", {d_en, busy, d_o.p, d_o.n, tx_ready}, {e.en, e.en, e.p, e.n, e.rdy});
        end
        if (d_en) run_len++;
        else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (tx_ready) rdy_cnt++;
    end

    // Model: list wire bits, then NRZI-encode and expand to clks.
    task automatic build_pkt(input bit fs, input logic [7:0] b[$]);
        bit bits[$];
        bit rdyb[$];
        int ones;
        int div;
        bit lvl_j;
        div = fs ? FS_DIV : LS_DIV;
        mdl_q.delete();
        for (int i = 0; i < SYNC_BITS; i++) begin
            bits.push_back(i == SYNC_BITS - 1);
            rdyb.push_back((i == SYNC_BITS - 1) && (b.size() > 0));
        end
        ones = 1;
        for (int k = 0; k < b.size(); k++) begin
            for (int j = 0; j < 8; j++) begin
                bits.push_back(b[k][j]);
                rdyb.push_back(1'b0);
                ones = b[k][j] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    rdyb.push_back(1'b0);
                    ones = 0;
                end
                if (j == 7) rdyb[rdyb.size() - 1] = (k + 1 < b.size());
            end
        end
        lvl_j = 1'b1;
        foreach (bits[i]) begin
            if (!bits[i]) lvl_j = !lvl_j;
            for (int c = 0; c < div; c++)
                mdl_q.push_back(lv(lvl_j, fs, 1'b1, rdyb[i] && (c == div - 1)));
        end
        for (int c = 0; c < 2 * div; c++) mdl_q.push_back('{en: 1'b1, p: 1'b0, n: 1'b0, rdy: 1'b0});
        for (int c = 0; c < div; c++) mdl_q.push_back(lv(1'b1, fs, 1'b1, 1'b0));
    endtask

    task automatic build_ka();
        mdl_q.delete();
        for (int c = 0; c < 2 * LS_DIV; c++) mdl_q.push_back('{en: 1'b1, p: 1'b0, n: 1'b0, rdy: 1'b0});
        for (int c = 0; c < LS_DIV; c++) mdl_q.push_back(lv(1'b1, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic run(input bit fs, input logic [7:0] b[$], input bit pkt, input bit ka,
                       input int tog_at, input int rst_at);
        int k;
        bit pend;
        bit act;
        int cyc;
        bit done;
        k = 0; pend = 0; act = pkt; cyc = 0; done = 0;
        @(negedge clk); #1; usb_full_speed = fs;
        @(negedge clk); #1;
        if (pkt) build_pkt(fs, b);
        else if (ka && !fs) build_ka();
        else mdl_q.delete();
        exp_q    = mdl_q;
        rdy_cnt  = 0;
        tx_valid = pkt;
        tx_data  = (b.size() > 0) ? b[0] : 8'h00;
        keep_alive = ka;
        while (!done && cyc < 20000) begin
            @(negedge clk); #1;
            cyc++;
            keep_alive = 1'b0;
            reset      = 1'b0;
            if (pend) begin k++; pend = 0; end
            if (cyc == tog_at) usb_full_speed = !usb_full_speed;
            if (cyc == rst_at) begin reset = 1'b1; act = 0; exp_q.delete(); end
            tx_valid = act && (k < b.size());
            tx_data  = (act && k < b.size()) ? b[k] : 8'h00;
            pend = tx_ready;
            if (!reset && exp_q.size() == 0 && !d_en && cyc > 3) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %0d cycles expected completion", cyc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_d_en", d_en, 0);
        chk("reset_tx_ready", tx_ready, 0);
        chk("reset_d_o", d_o, 2'b10);
        #1 reset = 1'b0;
        armed = 1'b1;

        // single 0x00, full speed
        q = {8'h00};
        build_pkt(1'b1, q);
        chk("mdl_len_00", mdl_q.size(), 76);
        chk("mdl_rdy_clk32", mdl_q[31].rdy, 1);
        n = 0; foreach (mdl_q[i]) if (mdl_q[i].rdy) n++;
        chk("mdl_rdy_count", n, 1);
        n = 0; foreach (mdl_q[i]) if (!mdl_q[i].p && !mdl_q[i].n) n++;
        chk("mdl_se0_clks", n, 8);
        chk("mdl_sync_b0_K", {mdl_q[0].p, mdl_q[0].n}, 2'b01);
        chk("mdl_sync_b1_J", {mdl_q[4].p, mdl_q[4].n}, 2'b10);
        chk("mdl_sync_b7_K", {mdl_q[28].p, mdl_q[28].n}, 2'b01);
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("den_len_00", last_run, 76);
        chk("rdy_pulses_00", rdy_cnt, 1);

        // 0xFF: one stuff bit mid-byte
        q = {8'hFF};
        build_pkt(1'b1, q);
        chk("mdl_len_ff", mdl_q.size(), 80);
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("den_len_ff", last_run, 80);
        chk("rdy_pulses_ff", rdy_cnt, 1);

        // stuff bit after the final data bit, before EOP
        q = {8'hFC};
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("den_len_fc", last_run, 80);

        // multi-byte with stuffing across byte boundaries
        q = {8'hA5, 8'h3F, 8'hFF, 8'h7E};
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("rdy_pulses_multi", rdy_cnt, 4);

        // zero-byte packet
        q = {};
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("den_len_zero", last_run, 44);
        chk("rdy_pulses_zero", rdy_cnt, 0);

        // low-speed keep-alive
        build_ka();
        chk("mdl_ka_len", mdl_q.size(), 96);
        chk("mdl_ka_j", {mdl_q[64].p, mdl_q[64].n}, 2'b01);
        run(1'b0, q, 1'b0, 1'b1, -1, -1);
        chk("den_len_ka", last_run, 96);

        // full-speed keep-alive ignored
        last_run = 0;
        run(1'b1, q, 1'b0, 1'b1, -1, -1);
        chk("fs_ka_ignored", last_run, 0);

        // low-speed packet with keep_alive arriving together (tx_valid wins)
        q = {8'h80, 8'h01};
        run(1'b0, q, 1'b1, 1'b1, -1, -1);
        chk("den_len_ls", last_run, 864);
        chk("rdy_pulses_ls", rdy_cnt, 2);

        // reset mid-DATA, then a fresh packet with full SYNC
        q = {8'h55, 8'hAA, 8'h55};
        run(1'b1, q, 1'b1, 1'b0, -1, 40);
        q = {8'h00};
        run(1'b1, q, 1'b1, 1'b0, -1, -1);
        chk("den_len_after_rst", last_run, 76);

        // speed toggled mid-packet: timing and polarity stay full-speed
        q = {8'h3C, 8'hC3};
        run(1'b1, q, 1'b1, 1'b0, 30, -1);
        chk("den_len_toggle", last_run, 108);

        // reset wins over tx_valid and keep_alive in the same clk
        @(negedge clk); #1;
        reset = 1'b1; tx_valid = 1'b1; keep_alive = 1'b1; tx_data = 8'h12;
        @(negedge clk); #1;
        chk("rst_prio_d_en", d_en, 0);
        reset = 1'b0; tx_valid = 1'b0; keep_alive = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
